instruction_decode: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
- Accepts a fetched {pc, instruction} pair over a valid/ready handshake and splits the instruction into fields.
- Generates the sign-extended immediate and reads a 32x32 register file that the writeback stage writes.
- Presents one registered entry to the execute stage, with backpressure and flush.

---
 rtl/instruction_decode.sv | 152 +++++++++++++++
 tb/tb_instruction_decode.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// RV32I decode stage: splits the fetched instruction, builds the immediate,
// reads the register file and holds one entry for execute.
module instruction_decode #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instruction,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  // The bubble encoding must decode as an ordinary OP-IMM so it needs no special path.
  if (XLEN != 32) begin : g_bad_xlen
    $error("instruction_decode supports XLEN=32 only");
  end
  if (NOP_INSTR[6:0] != OPC_OP_IMM) begin : g_bad_nop
    $error("NOP_INSTR must be an OP-IMM encoding");
  end

  logic [XLEN-1:0] regs [32];

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd_field;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic            no_rd;
  logic            accept;

  assign opcode   = if_instruction[6:0];
  assign rd_field = if_instruction[11:7];
  assign rs1      = if_instruction[19:15];
  assign rs2      = if_instruction[24:20];

  assign if_ready = !ex_valid || ex_ready;
  assign accept   = if_valid && if_ready && !flush;

  always_comb begin
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
    if (wb_we && wb_rd == rs1) rs1_val = wb_data;
    if (wb_we && wb_rd == rs2) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    no_rd   = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
        imm = {{20{if_instruction[31]}}, if_instruction[31:20]};
      OPC_STORE: begin
        imm   = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
        no_rd = 1'b1;
      end
      OPC_BRANCH: begin
        imm   = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                 if_instruction[30:25], if_instruction[11:8], 1'b0};
        no_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC:
        imm = {if_instruction[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
               if_instruction[20], if_instruction[30:21], 1'b0};
      OPC_OP, OPC_FENCE:
        imm = '0;
      default: begin
        // Also catches instr[1:0] != 2'b11, since every supported opcode ends in 11.
        illegal = 1'b1;
        no_rd   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_opcode    <= opcode;
      ex_funct3    <= if_instruction[14:12];
      ex_funct7_b5 <= if_instruction[30];
      ex_rs1       <= rs1;
      ex_rs2       <= rs2;
      ex_rd        <= no_rd ? 5'd0 : rd_field;
      ex_rs1_data  <= rs1_val;
      ex_rs2_data  <= rs2_val;
      ex_imm       <= imm;
      ex_illegal   <= illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed plan items plus random traffic,
// scored against an arithmetic reference model through a queue.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, flush, wb_we, ex_valid, ex_ready;
  logic        ex_funct7_b5, ex_illegal;
  logic [31:0] if_pc, if_instruction, wb_data, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  wb_rd, ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instruction(if_instruction),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        sb_q[$];
  logic [31:0] mregs [32];
  bit          exp_valid = 1'b0;
  bit          live = 1'b0;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  // Immediates rebuilt as weighted sums of instruction fields.
  function automatic ent_t ref_decode(input logic [31:0] pc, input logic [31:0] ins);
    ent_t e;
    int   si, hi;
    si = $signed(ins);
    e = '0;
    e.pc = pc;
    e.opcode = ins[6:0];
    e.funct3 = ins[14:12];
    e.f7b5 = ins[30];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd = ins[11:7];
    e.rs1_data = mread(ins[19:15]);
    e.rs2_data = mread(ins[24:20]);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        hi = si >>> 20;
        e.imm = 32'(hi);
      end
      7'h23: begin
        hi = si >>> 25;
        e.imm = 32'(hi) * 32'd32 + 32'(ins[11:7]);
        e.rd = 5'd0;
      end
      7'h63: begin
        hi = si >>> 31;
        e.imm = 32'(hi) * 32'd4096 + 32'(ins[7]) * 32'd2048 + 32'(ins[30:25]) * 32'd32
              + 32'(ins[11:8]) * 32'd2;
        e.rd = 5'd0;
      end
      7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
      7'h6F: begin
        hi = si >>> 31;
        e.imm = 32'(hi) * 32'd1048576 + 32'(ins[19:12]) * 32'd4096 + 32'(ins[20]) * 32'd2048
              + 32'(ins[30:21]) * 32'd2;
      end
      7'h33, 7'h0F: e.imm = 32'd0;
      default: begin
        e.illegal = 1'b1;
        e.rd = 5'd0;
        e.imm = 32'd0;
      end
    endcase
    return e;
  endfunction

  // Reference model: advances on each rising edge from the inputs presented.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      sb_q.delete();
      exp_valid = 1'b0;
      foreach (mregs[i]) mregs[i] = 32'd0;
      live = 1'b1;
    end else if (live) begin
      acc = if_valid && (!exp_valid || ex_ready) && !flush;
      if (flush) begin
        exp_valid = 1'b0;
        sb_q.delete();
      end else if (acc) begin
        sb_q.push_back(ref_decode(if_pc, if_instruction));
        exp_valid = 1'b1;
      end else if (exp_valid && ex_ready) begin
        exp_valid = 1'b0;
      end
      if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    end
  end

  // Monitor: compares whatever the DUT presents, pops when execute consumes.
  always @(negedge clk) begin
    ent_t act;
    if (live) begin
      checks++;
      if (ex_valid !== exp_valid) begin
        errors++;
        $display("FAIL ex_valid: got %0b want %0b at %0t", ex_valid, exp_valid, $time);
      end
      checks++;
      if (if_ready !== (!exp_valid || ex_ready)) begin
        errors++;
        $display("FAIL if_ready: got %0b want %0b at %0t", if_ready, (!exp_valid || ex_ready), $time);
      end
      if (exp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: entry presented but none expected at %0t", $time);
        end else begin
          act = '{ex_pc, ex_opcode, ex_funct3, ex_funct7_b5, ex_rs1, ex_rs2, ex_rd,
                  ex_rs1_data, ex_rs2_data, ex_imm, ex_illegal};
          if (act !== sb_q[0]) begin
            errors++;
            $display("FAIL entry: got %h want %h at %0t", act, sb_q[0], $time);
          end
          if (ex_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit fl, input bit we, input logic [4:0] rd, input logic [31:0] d,
                       input bit rdy);
    @(posedge clk);
    #1;
    rst = r; if_valid = v; if_pc = pc; if_instruction = ins; flush = fl;
    wb_we = we; wb_rd = rd; wb_data = d; ex_ready = rdy;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input bit rdy);
    drive(1'b0, 1'b1, pc, ins, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  logic [31:0] sw_ins [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'h001000EF};
  logic [31:0] sw_imm [4] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
  logic [4:0]  sw_rd  [4] = '{5'd0, 5'd0, 5'd1, 5'd1};
  logic [6:0]  ops    [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h33, 7'h0F};

  initial begin
    logic [31:0] ins;
    int          k;
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instruction = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b0;

    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_imm", ex_imm, 32'd0);
    chk("reset if_ready", 32'(if_ready), 32'd1);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h10, 1'b1);
    issue(32'h40, 32'hFFF28313, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("addi ex_valid", 32'(ex_valid), 32'd1);
    chk("addi ex_pc", ex_pc, 32'h40);
    chk("addi ex_rs1", 32'(ex_rs1), 32'd5);
    chk("addi ex_rs1_data", ex_rs1_data, 32'h10);
    chk("addi ex_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi ex_rd", 32'(ex_rd), 32'd6);
    chk("addi ex_illegal", 32'(ex_illegal), 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(32'h80 + 32'(i * 4), sw_ins[i], 1'b1);
      idle(1'b1);
      @(negedge clk);
      chk($sformatf("sweep%0d imm", i), ex_imm, sw_imm[i]);
      chk($sformatf("sweep%0d rd", i), 32'(ex_rd), 32'(sw_rd[i]));
    end

    drive(1'b0, 1'b1, 32'h100, 32'h00038433, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("bypass rs1_data", ex_rs1_data, 32'hDEADBEEF);
    chk("bypass rs2_data", ex_rs2_data, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h55, 1'b1);
    drive(1'b0, 1'b1, 32'h104, 32'h000004B3, 1'b0, 1'b1, 5'd0, 32'h55, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("x0 rs1_data", ex_rs1_data, 32'd0);
    chk("x0 rs2_data", ex_rs2_data, 32'd0);

    issue(32'h200, 32'h00500093, 1'b1);
    for (int i = 0; i < 3; i++) begin
      issue(32'h204, 32'h00108113, 1'b0);
      @(negedge clk);
      chk("stall if_ready", 32'(if_ready), 32'd0);
      chk("stall ex_pc", ex_pc, 32'h200);
      chk("stall ex_imm", ex_imm, 32'd5);
    end
    issue(32'h204, 32'h00108113, 1'b1);
    @(negedge clk);
    chk("release ex_pc A", ex_pc, 32'h200);
    issue(32'h208, 32'h00210193, 1'b1);
    @(negedge clk);
    chk("stream ex_pc B", ex_pc, 32'h204);
    issue(32'h20C, 32'h00318213, 1'b1);
    @(negedge clk);
    chk("stream ex_pc C", ex_pc, 32'h208);
    chk("stream ex_valid", 32'(ex_valid), 32'd1);
    idle(1'b1);
    @(negedge clk);
    chk("stream ex_pc D", ex_pc, 32'h20C);
    idle(1'b1);
    @(negedge clk);
    chk("drained ex_valid", 32'(ex_valid), 32'd0);

    issue(32'h300, 32'h00100293, 1'b1);
    drive(1'b0, 1'b1, 32'h304, 32'h00200313, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("preflush ex_pc", ex_pc, 32'h300);
    idle(1'b1);
    @(negedge clk);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);

    issue(32'h400, 32'h0000007F, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("illegal flag", 32'(ex_illegal), 32'd1);
    chk("illegal rd", 32'(ex_rd), 32'd0);
    chk("illegal imm", ex_imm, 32'd0);
    issue(32'h404, 32'h00000FFF, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("illegal rd forced", 32'(ex_rd), 32'd0);
    chk("illegal flag 2", 32'(ex_illegal), 32'd1);

    repeat (3000) begin
      ins = $urandom();
      k = int'($urandom_range(0, 11));
      if (k < 11) ins[6:0] = ops[k];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 255) == 0), ($urandom_range(0, 3) != 0), $urandom(), ins,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 3) != 0));
    end
    repeat (4) idle(1'b1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
